debounce_sync: RTL and testbench

//  Conditions one asynchronous, bouncy input (push-button or switch) for the single-bit

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/sync_chain.sv | 36 +++
 rtl/debounce_sync.sv | 138 +++++++++++++
 tb/tb_debounce_sync.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the debounce_sync block: the two-state FSM
//   encoding used by the debounce controller and a couple of small helpers
//   for sizing its qualification counter.
// ---------------------------------------------------------------------------
package debounce_pkg;

  // Debounce FSM state encoding.
  //   ST_STABLE : the synchronized input agrees with the committed Level.
  //   ST_WAIT   : a candidate transition is being qualified.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_e;

  // Smallest legal values for the block parameters.
  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 2;

  // Width needed to hold a count from 0 up to and including maxCount.
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   Plain multi-flop synchronizer for one asynchronous single-bit input.
//   There is deliberately no logic between the flops, so every stage after
//   the first has a full clock period to resolve metastability.
//
// Ports
//   Clk    in  1  clock, all flops update on posedge
//   Reset  in  1  synchronous, active-high; clears every stage
//   d      in  1  asynchronous input
//   q      out 1  synchronized copy of d, STAGES edges later
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages_q;

  // Shift the raw input through the chain; stage 0 is the only flop that
  // ever sees the asynchronous signal directly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[STAGES-2:0], d};
    end
  end

  assign q = stages_q[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//   Conditions one bouncy asynchronous input (push-button or switch).
//   The raw input is first synchronized, then a counter-based FSM requires
//   the synchronized value to differ from the committed Level for
//   DEBOUNCE_CYCLES consecutive cycles before Level follows it. A commit
//   also produces a one-cycle Rise or Fall strobe.
//
// Parameters
//   SYNC_STAGES      synchronizer depth, >= 2
//   DEBOUNCE_CYCLES  consecutive mismatching cycles needed to commit, >= 2
//
// Ports
//   Clk    in  1  clock, all state updates on posedge
//   Reset  in  1  synchronous, active-high, priority over everything
//   D_raw  in  1  asynchronous raw input
//   Level  out 1  debounced registered level
//   Rise   out 1  one-cycle strobe, Level went 0->1 on this edge
//   Fall   out 1  one-cycle strobe, Level went 1->0 on this edge
//   Busy   out 1  high while a candidate transition is being qualified
// ---------------------------------------------------------------------------
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D_raw,
  output logic Level,
  output logic Rise,
  output logic Fall,
  output logic Busy
);

  // Counter width is derived from DEBOUNCE_CYCLES and is not a parameter,
  // so nobody can accidentally make it too narrow to reach the last count.
  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  logic             mismatch;
  logic             commit;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  // Bring the raw input into the Clk domain before anything looks at it.
  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (D_raw),
    .q     (sync)
  );

  // A mismatch means the synchronized input disagrees with what we have
  // already committed, i.e. a transition candidate is present this cycle.
  assign mismatch = (sync != level_q);

  // All state lives here. Reset abandons any qualification in progress, so
  // a pending commit is simply dropped and no strobe is emitted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. cnt_d counts the consecutive mismatching cycles seen
  // so far, so the first mismatch loads 1 and the commit happens when the
  // DEBOUNCE_CYCLES-th one arrives (cnt already at DEBOUNCE_CYCLES-1).
  // Any agreeing cycle throws the candidate away and clears the count, which
  // also keeps the counter from ever exceeding DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    commit  = 1'b0;

    unique case (state_q)
      ST_STABLE: begin
        if (mismatch) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (!mismatch) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          commit  = 1'b1;
          level_d = sync;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  // Strobes are registered alongside Level so they rise on the same edge
  // that Level changes. Only one can be set because sync is a single bit.
  always_comb begin
    rise_d = commit & sync;
    fall_d = commit & ~sync;
    busy_d = (state_d == ST_WAIT);
  end

  assign Level = level_q;
  assign Rise  = rise_q;
  assign Fall  = fall_q;
  assign Busy  = busy_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
//   Self-checking bench for debounce_sync with SYNC_STAGES=2 and
//   DEBOUNCE_CYCLES=4. A behavioural model tracks the raw input history and
//   the length of the current run of cycles in which the delayed input
//   disagrees with the committed level; Level flips when that run reaches
//   DEBOUNCE_CYCLES. Directed scenarios are followed by a random bounce soak.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  logic Clk;
  logic Reset;
  logic D_raw;
  logic Level;
  logic Rise;
  logic Fall;
  logic Busy;

  int testCount = 0;
  int failCount = 0;

  // Model state: history of raw samples, newest at index 0.
  logic rawHist[SYNC_STAGES];
  logic mLevel;
  logic mRise;
  logic mFall;
  logic mBusy;
  int   mRun;

  // Edge counter used by the directed scenarios, plus soak bookkeeping.
  int   edgeIdx;
  int   riseSeen;
  int   fallSeen;
  logic prevLevel;

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .D_raw (D_raw),
    .Level (Level),
    .Rise  (Rise),
    .Fall  (Fall),
    .Busy  (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One compared bit: counts the check and reports a failure.
  task automatic checkBit(input string tag, input logic observed, input logic expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b at edge %0d", tag, observed, expected, edgeIdx);
    end
  endtask

  // Compares every output against the model after an edge.
  task automatic checkOutput();
    checkBit("level", Level, mLevel);
    checkBit("rise",  Rise,  mRise);
    checkBit("fall",  Fall,  mFall);
    checkBit("busy",  Busy,  mBusy);
    checkBit("no_rise_and_fall", Rise & Fall, 1'b0);
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic modelEdge(input logic raw, input logic rst);
    logic delayed;
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) rawHist[i] = 1'b0;
      mLevel = 1'b0;
      mRise  = 1'b0;
      mFall  = 1'b0;
      mRun   = 0;
    end else begin
      // The value the debouncer compares is the raw sample taken
      // SYNC_STAGES edges before this one.
      delayed = rawHist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) rawHist[i] = rawHist[i-1];
      rawHist[0] = raw;
      mRise = 1'b0;
      mFall = 1'b0;
      if (delayed != mLevel) begin
        mRun++;
        if (mRun == DEBOUNCE_CYCLES) begin
          mLevel = delayed;
          mRise  = delayed;
          mFall  = ~delayed;
          mRun   = 0;
        end
      end else begin
        mRun = 0;
      end
    end
    mBusy = (mRun != 0);
  endtask

  // Drive inputs, take one edge, update the model, then check #1 later.
  task automatic applyStimulus(input logic raw, input logic rst);
    prevLevel = Level;
    D_raw = raw;
    Reset = rst;
    @(posedge Clk);
    edgeIdx++;
    modelEdge(raw, rst);
    #1;
    if (Rise) riseSeen++;
    if (Fall) fallSeen++;
    checkOutput();
  endtask

  initial begin
    logic [8:0] bouncePat;
    logic       soakVal;
    int         holdLen;

    D_raw   = 1'b0;
    Reset   = 1'b1;
    edgeIdx = 0;
    riseSeen = 0;
    fallSeen = 0;
    prevLevel = 1'b0;
    mLevel = 1'b0; mRise = 1'b0; mFall = 1'b0; mBusy = 1'b0; mRun = 0;
    for (int i = 0; i < SYNC_STAGES; i++) rawHist[i] = 1'b0;

    // 1: reset for three cycles, then one cycle released with D_raw low.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkBit("t1_level_in_reset", Level, 1'b0);
      checkBit("t1_busy_in_reset", Busy, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkBit("t1_level_after", Level, 1'b0);

    // 2: D_raw goes high and holds; edge 1 is its first sample.
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 2) checkBit("t2_busy_e2", Busy, 1'b0);
      if (e == 3) checkBit("t2_busy_e3", Busy, 1'b1);
      if (e == 5) checkBit("t2_level_e5", Level, 1'b0);
      if (e == 6) begin
        checkBit("t2_level_e6", Level, 1'b1);
        checkBit("t2_rise_e6", Rise, 1'b1);
      end
      if (e == 7) begin
        checkBit("t2_rise_e7", Rise, 1'b0);
        checkBit("t2_busy_e7", Busy, 1'b0);
      end
    end

    // 3: a 3-cycle low is rejected, a 4-cycle low commits a single Fall.
    fallSeen = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkBit("t3_level_kept", Level, 1'b1);
    checkBit("t3_busy_idle", Busy, 1'b0);
    checkBit("t3_no_fall", fallSeen == 0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
    checkBit("t3_level_low", Level, 1'b0);
    checkBit("t3_one_fall", fallSeen == 1, 1'b1);

    // 4: bounce 1,0,1,1,0,1,1,1,1 then hold high.
    riseSeen = 0;
    bouncePat = 9'b1_1110_1101;
    for (int i = 0; i < 9; i++) applyStimulus(bouncePat[i], 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkBit("t4_level_high", Level, 1'b1);
    checkBit("t4_one_rise", riseSeen == 1, 1'b1);

    // 5: start a fall qualification, reset once cnt has reached 2.
    for (int e = 1; e <= 4; e++) applyStimulus(1'b0, 1'b0);
    checkBit("t5_busy_before_reset", Busy, 1'b1);
    fallSeen = 0;
    applyStimulus(1'b0, 1'b1);
    checkBit("t5_busy_after_reset", Busy, 1'b0);
    checkBit("t5_level_after_reset", Level, 1'b0);
    checkBit("t5_no_fall_strobe", fallSeen == 0, 1'b1);

    // 6: release reset with D_raw held high.
    riseSeen = 0;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, 1'b0);
      if (e == 5) checkBit("t6_level_e5", Level, 1'b0);
      if (e == 6) begin
        checkBit("t6_level_e6", Level, 1'b1);
        checkBit("t6_rise_e6", Rise, 1'b1);
      end
    end
    checkBit("t6_one_rise", riseSeen == 1, 1'b1);

    // Random bounce soak: runs of random value and length; strobes must
    // alternate, which shows as each strobe leaving the opposite level.
    soakVal = 1'b1;
    for (int r = 0; r < 150; r++) begin
      soakVal = ($urandom_range(0, 3) == 0) ? soakVal : ~soakVal;
      holdLen = $urandom_range(1, 8);
      for (int k = 0; k < holdLen; k++) begin
        applyStimulus(soakVal, 1'b0);
        if (Rise) checkBit("soak_rise_from_low", prevLevel, 1'b0);
        if (Fall) checkBit("soak_fall_from_high", prevLevel, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule : tb_debounce_sync
